// File: rtl/lc3_mem_responder.sv
// Wait-stated word RAM responder behind the LC-3 MAR/MDR interface; one-cycle ready pulse per access.
// Optional display MMIO (DSR at FE04, DDR at FE06) is enabled by defining LC3_MEM_MMIO_EN.
module lc3_mem_responder #(
    parameter int ADDR_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        r_w,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        ready
`ifdef LC3_MEM_MMIO_EN
    ,
    output logic        ddr_valid,
    output logic [15:0] ddr_data
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t              state_r;
    logic [3:0]          cnt_r;
    logic [ADDR_W-1:0]   addr_r;
    logic                rw_r;
    logic [15:0]         data_r;
    logic [15:0]         data_out_r;
    logic                ready_r;
    logic [15:0]         ram_r [0:(2**ADDR_W)-1];

    logic                access_s;
    logic                ram_we_s;
    logic [15:0]         rd_data_s;

`ifdef LC3_MEM_MMIO_EN
    logic                is_dsr_s;
    logic                is_ddr_s;
    logic                ddr_valid_r;
    logic [15:0]         ddr_data_r;
`endif

    // Access strobe, RAM write enable and read-data selection for the latched request
    always_comb begin
        access_s  = (state_r == BUSY) && (cnt_r == 4'd0);
        ram_we_s  = 1'b0;
        rd_data_s = ram_r[addr_r];
`ifdef LC3_MEM_MMIO_EN
        is_dsr_s  = (addr_r == ADDR_W'(16'hFE04));
        is_ddr_s  = (addr_r == ADDR_W'(16'hFE06));
        if (is_dsr_s) begin
            rd_data_s = 16'h8000;
        end else if (is_ddr_s) begin
            rd_data_s = ddr_data_r;
        end else begin
            rd_data_s = ram_r[addr_r];
        end
        if (access_s && rw_r && !is_ddr_s) begin
            ram_we_s = 1'b1;
        end else begin
            ram_we_s = 1'b0;
        end
`else
        if (access_s && rw_r) begin
            ram_we_s = 1'b1;
        end else begin
            ram_we_s = 1'b0;
        end
`endif
    end

    // RAM array write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            ram_r[addr_r] <= data_r;
        end
    end

    // Request FSM: latch in IDLE, count wait states in BUSY, pulse ready into DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            addr_r      <= '0;
            rw_r        <= 1'b0;
            data_r      <= 16'h0000;
            data_out_r  <= 16'h0000;
            ready_r     <= 1'b0;
`ifdef LC3_MEM_MMIO_EN
            ddr_valid_r <= 1'b0;
            ddr_data_r  <= 16'h0000;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b0;
                    if (cs) begin
                        addr_r  <= addr[ADDR_W-1:0];
                        rw_r    <= r_w;
                        data_r  <= data_in;
                        cnt_r   <= WAIT_INIT;
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        ready_r <= 1'b1;
                        state_r <= DONE;
                        if (!rw_r) begin
                            data_out_r <= rd_data_s;
                        end
`ifdef LC3_MEM_MMIO_EN
                        if (rw_r && is_ddr_s) begin
                            ddr_data_r  <= data_r;
                            ddr_valid_r <= 1'b1;
                        end
`endif
                    end
                end
                DONE: begin
                    ready_r <= 1'b0;
                    state_r <= IDLE;
`ifdef LC3_MEM_MMIO_EN
                    ddr_valid_r <= 1'b0;
`endif
                end
                default: begin
                    ready_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign data_out = data_out_r;
    assign ready    = ready_r;
`ifdef LC3_MEM_MMIO_EN
    assign ddr_valid = ddr_valid_r;
    assign ddr_data  = ddr_data_r;
`endif

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Self-checking bench for lc3_mem_responder: vector table, directed corner sequences,
// and random accesses against an associative-array memory model.
module tb_lc3_mem_responder;

    localparam int W = 2;

    logic        clk;
    logic        rst;
    logic        cs;
    logic        r_w;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        ready;
`ifdef LC3_MEM_MMIO_EN
    logic        ddr_valid;
    logic [15:0] ddr_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] model_mem [int];
    logic [15:0] written_q [$];

    typedef struct {
        logic        rw;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_out;
    } vec_t;

    vec_t vecs [8];

    lc3_mem_responder #(.ADDR_W(16), .WAIT_CYCLES(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .cs       (cs),
        .r_w      (r_w),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
        .ready    (ready)
`ifdef LC3_MEM_MMIO_EN
        ,
        .ddr_valid(ddr_valid),
        .ddr_data (ddr_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One full handshake; checks latency W+1 and a single-cycle ready pulse.
    task automatic do_access(input logic rw, input logic [15:0] a, input logic [15:0] d,
                             input string tag, output logic [15:0] rd);
        int edges;
        cs = 1'b1; r_w = rw; addr = a; data_in = d;
        @(posedge clk); #1;
        edges = 0;
        while (ready !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        check({tag, " latency"}, edges, W + 1);
        rd = data_out;
        cs = 1'b0;
        @(posedge clk); #1;
        check({tag, " pulse width"}, {31'd0, ready}, 32'd0);
    endtask

    function automatic void model_write(input logic [15:0] a, input logic [15:0] d);
        if (!model_mem.exists(int'(a))) written_q.push_back(a);
        model_mem[int'(a)] = d;
    endfunction

    initial begin
        logic [15:0] rd;
        logic [15:0] exp_out;
        int          edges;
        int          seen;

        rst = 1'b0; cs = 1'b0; r_w = 1'b0; addr = 16'h0000; data_in = 16'h0000;
        #12;
        check("reset ready", {31'd0, ready}, 32'd0);
        check("reset data_out", {16'd0, data_out}, 32'h0000);
`ifdef LC3_MEM_MMIO_EN
        check("reset ddr_valid", {31'd0, ddr_valid}, 32'd0);
        check("reset ddr_data", {16'd0, ddr_data}, 32'h0000);
`endif
        rst = 1'b1;
        @(posedge clk); #1;

        // Vector table: data_out after each access (writes must leave it alone)
        vecs[0] = '{1'b1, 16'h0000, 16'h1111, 16'h0000};
        vecs[1] = '{1'b1, 16'hFFFF, 16'h2222, 16'h0000};
        vecs[2] = '{1'b0, 16'h0000, 16'h0000, 16'h1111};
        vecs[3] = '{1'b1, 16'h8000, 16'hFFFF, 16'h1111};
        vecs[4] = '{1'b0, 16'hFFFF, 16'h0000, 16'h2222};
        vecs[5] = '{1'b1, 16'h0000, 16'h3333, 16'h2222};
        vecs[6] = '{1'b0, 16'h0000, 16'h0000, 16'h3333};
        vecs[7] = '{1'b0, 16'h8000, 16'h0000, 16'hFFFF};
        for (int i = 0; i < 8; i++) begin
            do_access(vecs[i].rw, vecs[i].addr, vecs[i].wdata, $sformatf("vec%0d", i), rd);
            check($sformatf("vec%0d data_out", i), {16'd0, rd}, {16'd0, vecs[i].exp_out});
            if (vecs[i].rw) model_write(vecs[i].addr, vecs[i].wdata);
        end

        // Random accesses against the model
        exp_out = 16'hFFFF;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] a;
            logic [15:0] d;
            if (written_q.size() < 3 || $urandom_range(0, 1) == 0) begin
                a = 16'h1000 + 16'($urandom_range(0, 31));
                d = 16'($urandom);
                do_access(1'b1, a, d, $sformatf("rnd%0d wr", i), rd);
                model_write(a, d);
                check($sformatf("rnd%0d wr keeps data_out", i), {16'd0, rd}, {16'd0, exp_out});
            end else begin
                a = written_q[$urandom_range(0, written_q.size() - 1)];
                do_access(1'b0, a, 16'h0000, $sformatf("rnd%0d rd", i), rd);
                exp_out = model_mem[int'(a)];
                check($sformatf("rnd%0d rd %h", i, a), {16'd0, rd}, {16'd0, exp_out});
            end
        end

        // Write then read back 3000
        do_access(1'b1, 16'h3000, 16'hBEEF, "wr3000", rd);
        do_access(1'b0, 16'h3000, 16'h0000, "rd3000", rd);
        check("rd3000 data", {16'd0, rd}, 32'hBEEF);

        // Async reset while ready is high clears outputs without a clock edge
        cs = 1'b1; r_w = 1'b0; addr = 16'h3000;
        @(posedge clk); #1;
        repeat (W + 1) begin @(posedge clk); #1; end
        check("pre-reset ready", {31'd0, ready}, 32'd1);
        check("pre-reset data", {16'd0, data_out}, 32'hBEEF);
        cs = 1'b0;
        rst = 1'b0;
        #2;
        check("async rst ready", {31'd0, ready}, 32'd0);
        check("async rst data_out", {16'd0, data_out}, 32'h0000);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        check("post-reset idle ready", {31'd0, ready}, 32'd0);

        // Back-to-back: cs held through ready, second access to 3001
        do_access(1'b1, 16'h3001, 16'h7777, "wr3001", rd);
        cs = 1'b1; r_w = 1'b0; addr = 16'h3000;
        @(posedge clk); #1;
        edges = 0;
        while (ready !== 1'b1 && edges < 40) begin @(posedge clk); #1; edges++; end
        check("b2b first latency", edges, W + 1);
        check("b2b first data", {16'd0, data_out}, 32'hBEEF);
        addr = 16'h3001;
        @(posedge clk); #1;
        check("b2b first falls", {31'd0, ready}, 32'd0);
        edges = 0;
        while (ready !== 1'b1 && edges < 40) begin @(posedge clk); #1; edges++; end
        check("b2b gap after fall", edges, W + 2);
        check("b2b second data", {16'd0, data_out}, 32'h7777);
        cs = 1'b0;
        @(posedge clk); #1;
        check("b2b second falls", {31'd0, ready}, 32'd0);

        // Inputs changing during BUSY are ignored
        do_access(1'b1, 16'h4000, 16'h5555, "wr4000", rd);
        cs = 1'b1; r_w = 1'b0; addr = 16'h3000;
        @(posedge clk); #1;
        cs = 1'b0; r_w = 1'b1; addr = 16'h4000; data_in = 16'hFFFF;
        edges = 0;
        while (ready !== 1'b1 && edges < 40) begin @(posedge clk); #1; edges++; end
        check("busy-change latency", edges, W + 1);
        check("busy-change data", {16'd0, data_out}, 32'hBEEF);
        @(posedge clk); #1;
        check("busy-change pulse", {31'd0, ready}, 32'd0);
        do_access(1'b0, 16'h4000, 16'h0000, "rd4000", rd);
        check("4000 untouched", {16'd0, rd}, 32'h5555);

        // Reset during BUSY of a write aborts it
        cs = 1'b1; r_w = 1'b1; addr = 16'h3000; data_in = 16'h1234;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cs = 1'b0;
        rst = 1'b0;
        #2 rst = 1'b1;
        seen = 0;
        repeat (W + 4) begin
            @(posedge clk); #1;
            if (ready === 1'b1) seen++;
        end
        check("aborted write no ready", seen, 0);
        do_access(1'b0, 16'h3000, 16'h0000, "rd3000 after abort", rd);
        check("aborted write no effect", {16'd0, rd}, 32'hBEEF);

`ifdef LC3_MEM_MMIO_EN
        cs = 1'b1; r_w = 1'b1; addr = 16'hFE06; data_in = 16'h0041;
        @(posedge clk); #1;
        edges = 0;
        while (ready !== 1'b1 && edges < 40) begin @(posedge clk); #1; edges++; end
        check("ddr latency", edges, W + 1);
        check("ddr_valid with ready", {31'd0, ddr_valid}, 32'd1);
        check("ddr_data", {16'd0, ddr_data}, 32'h0041);
        cs = 1'b0;
        @(posedge clk); #1;
        check("ddr_valid one cycle", {31'd0, ddr_valid}, 32'd0);
        do_access(1'b0, 16'hFE04, 16'h0000, "rd dsr", rd);
        check("dsr value", {16'd0, rd}, 32'h8000);
        do_access(1'b0, 16'hFE06, 16'h0000, "rd ddr", rd);
        check("ddr readback", {16'd0, rd}, 32'h0041);
`else
        do_access(1'b1, 16'hFE04, 16'hA5A5, "wr fe04", rd);
        do_access(1'b0, 16'hFE04, 16'h0000, "rd fe04", rd);
        check("fe04 is ram", {16'd0, rd}, 32'hA5A5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
